decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 115 +++++++++++
 rtl/decode_stage_hazard_detect.sv | 22 ++
 rtl/decode_stage.sv | 154 +++++++++++++++
 tb/tb_decode_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU operation codes,
// the registered control bundle and the combinational instruction decoder.
// Used by decode_stage and its testbench; no state lives here.
package decode_stage_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes carried to EX
   localparam int         ALU_CODE_W = 4;
   localparam logic [3:0] ALU_OP_AND = 4'd0;
   localparam logic [3:0] ALU_OP_OR  = 4'd1;
   localparam logic [3:0] ALU_OP_ADD = 4'd2;
   localparam logic [3:0] ALU_OP_SUB = 4'd6;
   localparam logic [3:0] ALU_OP_SLT = 4'd7;

   // Control bundle registered into the output stage
   typedef struct packed {
      logic                  alu_src;
      logic                  mem_to_reg;
      logic                  reg_write;
      logic                  mem_read;
      logic                  mem_write;
      logic                  branch;
      logic                  branch_ne;
      logic                  jmp;
      logic                  illegal;
      logic [ALU_CODE_W-1:0] alu_op;
      logic [4:0]            dst;
   } ctrl_t;

   // Ops whose rt field is a source operand (matters for load-use hazards)
   function automatic logic reads_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   // Decode one instruction into controls; unknown op/funct yields a pure
   // illegal marker with every side-effecting control low. A write to $0 is
   // folded into "no write" so EX/WB never see a live dst of zero.
   function automatic ctrl_t decode_instr(input logic [5:0] op,
                                          input logic [5:0] funct,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
      ctrl_t c;
      c = '0;
      case (op)
         OP_RTYPE: begin
            c.reg_write = 1'b1;
            c.dst       = rd;
            case (funct)
               FN_ADD:  c.alu_op = ALU_OP_ADD;
               FN_SUB:  c.alu_op = ALU_OP_SUB;
               FN_AND:  c.alu_op = ALU_OP_AND;
               FN_OR:   c.alu_op = ALU_OP_OR;
               FN_SLT:  c.alu_op = ALU_OP_SLT;
               default: begin
                  c.illegal   = 1'b1;
                  c.reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI: begin
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.alu_op    = ALU_OP_ADD;
            c.dst       = rt;
         end
         OP_LW: begin
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_op     = ALU_OP_ADD;
            c.dst        = rt;
         end
         OP_SW: begin
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.alu_op    = ALU_OP_ADD;
         end
         OP_BEQ: begin
            c.branch = 1'b1;
            c.alu_op = ALU_OP_SUB;
         end
         OP_BNE: begin
            c.branch    = 1'b1;
            c.branch_ne = 1'b1;
            c.alu_op    = ALU_OP_SUB;
         end
         OP_J: begin
            c.jmp = 1'b1;
         end
         default: begin
            c.illegal = 1'b1;
         end
      endcase
      if (!c.reg_write) c.dst = 5'd0;
      if (c.dst == 5'd0) c.reg_write = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/decode_stage_hazard_detect.sv
// Load-use hazard detector: flags an incoming instruction that reads the
// destination of a load currently in EX. Purely combinational, no latency;
// the stall it produces holds fetch and injects a bubble downstream.
module hazard_detect (
   input  logic       in_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_dst,
   input  logic [4:0] rs,
   input  logic [4:0] rt,
   input  logic       uses_rt,
   output logic       stall
);

   logic rs_hit;
   logic rt_hit;

   // $0 is never a real dependency, so a zero ex_dst never stalls
   assign rs_hit = (ex_dst == rs);
   assign rt_hit = uses_rt && (ex_dst == rt);
   assign stall  = in_valid && ex_mem_read && (ex_dst != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction -> registered control/operand bundle. Load-use
// stall logic is built only when DECODE_HAZARD_EN is defined.
// Latency 1 cycle; holds outputs while out_ready=0, bubbles on stall/flush.
module decode_stage
   import decode_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instr,
   input  logic [XLEN-1:0]     in_pc,
   input  logic                ex_mem_read,
   input  logic [4:0]          ex_dst,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_alu_src,
   output logic                out_mem_to_reg,
   output logic                out_reg_write,
   output logic                out_mem_read,
   output logic                out_mem_write,
   output logic                out_branch,
   output logic                out_branch_ne,
   output logic                out_jmp,
   output logic                out_illegal,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic [4:0]          out_rs,
   output logic [4:0]          out_rt,
   output logic [4:0]          out_dst,
   output logic [XLEN-1:0]     out_imm,
   output logic [XLEN-1:0]     out_jtarget,
   output logic [XLEN-1:0]     out_pc
);

   // Instruction fields
   logic [5:0] op;
   logic [5:0] funct;
   logic [4:0] rs;
   logic [4:0] rt;
   logic [4:0] rd;

   assign op    = in_instr[31:26];
   assign rs    = in_instr[25:21];
   assign rt    = in_instr[20:16];
   assign rd    = in_instr[15:11];
   assign funct = in_instr[5:0];

   // Combinational decode and operand formation
   ctrl_t           dec;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] jtarget;

   assign dec      = decode_instr(op, funct, rt, rd);
   assign pc_plus4 = in_pc + XLEN'(4);
   assign imm_ext  = {{(XLEN-16){in_instr[15]}}, in_instr[15:0]};
   // Region bits come from pc+4, so a PC at the top of the space wraps to 0
   assign jtarget  = {pc_plus4[XLEN-1:28], in_instr[25:0], 2'b00};

   // Low bits of pc+4 are replaced by the jump index
   logic unused_pc_low;
   assign unused_pc_low = ^pc_plus4[27:0];

   // Load-use stall
   logic stall;
`ifdef DECODE_HAZARD_EN
   logic uses_rt;
   assign uses_rt = reads_rt(op);

   hazard_detect u_hazard_detect (
      .in_valid    (in_valid),
      .ex_mem_read (ex_mem_read),
      .ex_dst      (ex_dst),
      .rs          (rs),
      .rt          (rt),
      .uses_rt     (uses_rt),
      .stall       (stall)
   );
`else
   // EX status ports stay on the boundary but have no effect in this build
   logic unused_ex_status;
   assign unused_ex_status = ^{ex_mem_read, ex_dst};
   assign stall = 1'b0;
`endif

   // Handshake: the output slot frees when empty or being drained
   logic slot_free;
   logic take;

   assign slot_free = !out_valid || out_ready;
   assign take      = in_valid && !stall;
   assign in_ready  = slot_free && !stall && !flush;

   // Output register state
   logic            valid_q;
   ctrl_t           ctrl_q;
   logic [4:0]      rs_q;
   logic [4:0]      rt_q;
   logic [XLEN-1:0] imm_q;
   logic [XLEN-1:0] jtarget_q;
   logic [XLEN-1:0] pc_q;

   // Reset > flush > slot update; a bubble clears controls, operands keep value
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         imm_q     <= '0;
         jtarget_q <= '0;
         pc_q      <= '0;
      end else if (flush) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
      end else if (slot_free) begin
         if (take) begin
            valid_q   <= 1'b1;
            ctrl_q    <= dec;
            rs_q      <= rs;
            rt_q      <= rt;
            imm_q     <= imm_ext;
            jtarget_q <= jtarget;
            pc_q      <= in_pc;
         end else begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
         end
      end
   end

   assign out_valid      = valid_q;
   assign out_alu_src    = ctrl_q.alu_src;
   assign out_mem_to_reg = ctrl_q.mem_to_reg;
   assign out_reg_write  = ctrl_q.reg_write;
   assign out_mem_read   = ctrl_q.mem_read;
   assign out_mem_write  = ctrl_q.mem_write;
   assign out_branch     = ctrl_q.branch;
   assign out_branch_ne  = ctrl_q.branch_ne;
   assign out_jmp        = ctrl_q.jmp;
   assign out_illegal    = ctrl_q.illegal;
   assign out_alu_op     = ALU_OP_W'(ctrl_q.alu_op);
   assign out_dst        = ctrl_q.dst;
   assign out_rs         = rs_q;
   assign out_rt         = rt_q;
   assign out_imm        = imm_q;
   assign out_jtarget    = jtarget_q;
   assign out_pc         = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboard of expected decode bundles pushed on
// input handshake and popped on output handshake, plus scenario checks.
// Covers DECODE_HAZARD_EN both ways via the same macro.
`timescale 1ns/1ps
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        ex_mem_read;
   logic [4:0]  ex_dst;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic        out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write;
   logic        out_branch, out_branch_ne, out_jmp, out_illegal;
   logic [3:0]  out_alu_op;
   logic [4:0]  out_rs, out_rt, out_dst;
   logic [31:0] out_imm, out_jtarget, out_pc;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_src(out_alu_src), .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_branch(out_branch),
      .out_branch_ne(out_branch_ne), .out_jmp(out_jmp), .out_illegal(out_illegal),
      .out_alu_op(out_alu_op), .out_rs(out_rs), .out_rt(out_rt), .out_dst(out_dst),
      .out_imm(out_imm), .out_jtarget(out_jtarget), .out_pc(out_pc)
   );

   typedef struct packed {
      logic        alu_src, mem_to_reg, reg_write, mem_read, mem_write;
      logic        branch, branch_ne, jmp, illegal;
      logic [3:0]  alu_op;
      logic [4:0]  rs, rt, dst;
      logic [31:0] imm, jtarget, pc;
   } exp_t;

   exp_t sb_q[$];
   exp_t obs;
   int   checks   = 0;
   int   failures = 0;

   assign obs = {out_alu_src, out_mem_to_reg, out_reg_write, out_mem_read, out_mem_write,
                 out_branch, out_branch_ne, out_jmp, out_illegal, out_alu_op,
                 out_rs, out_rt, out_dst, out_imm, out_jtarget, out_pc};

   // Instruction encoders
   function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] fn);
      return {6'b000000, s, t, d, 5'd0, fn};
   endfunction
   function automatic logic [31:0] itype(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
      return {o, s, t, im};
   endfunction

   // Reference decoder
   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t        e;
      logic [31:0] nxt;
      logic [4:0]  tgt;
      logic        wr;
      e       = '0;
      tgt     = 5'd0;
      wr      = 1'b0;
      e.rs    = ins[25:21];
      e.rt    = ins[20:16];
      e.pc    = pc;
      e.imm   = {{16{ins[15]}}, ins[15:0]};
      nxt     = pc + 32'd4;
      e.jtarget = {nxt[31:28], ins[25:0], 2'b00};
      case (ins[31:26])
         6'h00: begin
            case (ins[5:0])
               6'h20:   begin e.alu_op = ALU_OP_ADD; wr = 1'b1; tgt = ins[15:11]; end
               6'h22:   begin e.alu_op = ALU_OP_SUB; wr = 1'b1; tgt = ins[15:11]; end
               6'h24:   begin e.alu_op = ALU_OP_AND; wr = 1'b1; tgt = ins[15:11]; end
               6'h25:   begin e.alu_op = ALU_OP_OR;  wr = 1'b1; tgt = ins[15:11]; end
               6'h2a:   begin e.alu_op = ALU_OP_SLT; wr = 1'b1; tgt = ins[15:11]; end
               default: e.illegal = 1'b1;
            endcase
         end
         6'h08: begin e.alu_src = 1'b1; e.alu_op = ALU_OP_ADD; wr = 1'b1; tgt = ins[20:16]; end
         6'h23: begin
            e.alu_src = 1'b1; e.mem_read = 1'b1; e.mem_to_reg = 1'b1;
            e.alu_op = ALU_OP_ADD; wr = 1'b1; tgt = ins[20:16];
         end
         6'h2b: begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.alu_op = ALU_OP_ADD; end
         6'h04: begin e.branch = 1'b1; e.alu_op = ALU_OP_SUB; end
         6'h05: begin e.branch = 1'b1; e.branch_ne = 1'b1; e.alu_op = ALU_OP_SUB; end
         6'h02: e.jmp = 1'b1;
         default: e.illegal = 1'b1;
      endcase
      e.reg_write = wr && (tgt != 5'd0);
      e.dst       = e.reg_write ? tgt : 5'd0;
      return e;
   endfunction

   // One cycle: evaluate both handshakes just after the negedge, then advance
   task automatic tick();
      exp_t e;
      #1;
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_output actual=%h required=no output", obs);
         end else begin
            e = sb_q.pop_front();
            if (obs !== e) begin
               failures++;
               $display("FAIL sb_output pc=%h actual=%h required=%h", e.pc, obs, e);
            end
         end
      end
      if (flush) sb_q.delete();
      if (!rst && in_valid && in_ready) sb_q.push_back(ref_model(in_instr, in_pc));
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00430820; in_pc = 32'h0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
      checks++; if (obs !== '0) begin failures++; $display("FAIL reset_outputs actual=%h required=0", obs); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_discard actual=%b required=0", out_valid); end
   endtask

   task automatic test_add();
      in_valid = 1'b1; in_instr = 32'h00430820; in_pc = 32'h00001000; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid actual=%b required=1", out_valid); end
      checks++; if (out_reg_write !== 1'b1) begin failures++; $display("FAIL add_reg_write actual=%b required=1", out_reg_write); end
      checks++; if (out_dst !== 5'd1) begin failures++; $display("FAIL add_dst actual=%0d required=1", out_dst); end
      checks++; if (out_alu_op !== ALU_OP_ADD) begin failures++; $display("FAIL add_alu_op actual=%0d required=%0d", out_alu_op, ALU_OP_ADD); end
      tick();
   endtask

   task automatic test_lw();
      in_valid = 1'b1; in_instr = 32'h8CC5FFFC; in_pc = 32'h00001004; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL lw_imm actual=%h required=fffffffc", out_imm); end
      checks++; if (out_mem_read !== 1'b1) begin failures++; $display("FAIL lw_mem_read actual=%b required=1", out_mem_read); end
      checks++; if (out_mem_to_reg !== 1'b1) begin failures++; $display("FAIL lw_mem_to_reg actual=%b required=1", out_mem_to_reg); end
      checks++; if (out_dst !== 5'd5) begin failures++; $display("FAIL lw_dst actual=%0d required=5", out_dst); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] prog [12];
      logic [31:0] pcs  [12];
      prog[0]  = rtype(5'd1, 5'd2, 5'd0, 6'h20);          // add to $0: write suppressed
      prog[1]  = rtype(5'd4, 5'd5, 5'd6, 6'h22);          // sub
      prog[2]  = rtype(5'd7, 5'd8, 5'd9, 6'h24);          // and
      prog[3]  = rtype(5'd10, 5'd11, 5'd12, 6'h25);       // or
      prog[4]  = rtype(5'd13, 5'd14, 5'd15, 6'h2a);       // slt
      prog[5]  = itype(6'h08, 5'd3, 5'd7, 16'h8000);      // addi negative imm
      prog[6]  = itype(6'h08, 5'd3, 5'd0, 16'h0001);      // addi to $0
      prog[7]  = itype(6'h2b, 5'd1, 5'd2, 16'h0010);      // sw
      prog[8]  = itype(6'h04, 5'd3, 5'd4, 16'hFFFF);      // beq
      prog[9]  = itype(6'h05, 5'd3, 5'd4, 16'h0004);      // bne
      prog[10] = {6'h02, 26'h3FFFFFF};                    // j at top of space
      prog[11] = rtype(5'd1, 5'd2, 5'd3, 6'h21);          // unknown funct
      for (int i = 0; i < 12; i++) pcs[i] = 32'h00002000 + 32'(i * 4);
      pcs[10] = 32'hFFFFFFFC;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         in_valid = 1'b1; in_instr = prog[i]; in_pc = pcs[i];
         tick();
         if (i == 10) begin
            checks++;
            if (out_jtarget !== 32'h0FFFFFFC) begin
               failures++; $display("FAIL jtarget_wrap actual=%h required=0ffffffc", out_jtarget);
            end
         end
      end
      in_valid = 1'b0;
      tick();
      tick();
      checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL b2b_pending actual=%0d required=0", sb_q.size()); end
   endtask

   task automatic test_backpressure();
      exp_t snap;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = rtype(5'd2, 5'd3, 5'd4, 6'h25); in_pc = 32'h00003000;
      tick();
      out_ready = 1'b0; in_instr = itype(6'h23, 5'd9, 5'd8, 16'h0020); in_pc = 32'h00003004;
      #1;
      snap = obs;
      for (int k = 0; k < 3; k++) begin
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d actual=%b required=0", k, in_ready); end
         tick();
         checks++;
         if (out_valid !== 1'b1 || obs !== snap) begin
            failures++; $display("FAIL bp_hold cyc=%0d actual=%b/%h required=1/%h", k, out_valid, obs, snap);
         end
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL bp_pending actual=%0d required=0", sb_q.size()); end
   endtask

   task automatic test_flush_illegal();
      out_ready = 1'b1; in_valid = 1'b1; in_instr = rtype(5'd5, 5'd6, 5'd7, 6'h20); in_pc = 32'h00004000;
      tick();
      out_ready = 1'b0; in_instr = rtype(5'd1, 5'd1, 5'd1, 6'h22); in_pc = 32'h00004004; flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready actual=%b required=0", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid actual=%b required=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drop actual=%b required=0", out_valid); end
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h00004008;
      tick();
      in_valid = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ill_valid actual=%b required=1", out_valid); end
      checks++; if (out_illegal !== 1'b1) begin failures++; $display("FAIL ill_flag actual=%b required=1", out_illegal); end
      checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL ill_reg_write actual=%b required=0", out_reg_write); end
      checks++; if (out_mem_write !== 1'b0) begin failures++; $display("FAIL ill_mem_write actual=%b required=0", out_mem_write); end
      tick();
   endtask

   task automatic test_hazard();
      out_ready = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd2;
      in_valid = 1'b1; in_instr = 32'h00430820; in_pc = 32'h00005000;
      #1;
`ifdef DECODE_HAZARD_EN
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hz_stall actual=%b required=0", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hz_bubble actual=%b required=0", out_valid); end
      ex_mem_read = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hz_release actual=%b required=1", in_ready); end
      tick();
`else
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hz_ignored actual=%b required=1", in_ready); end
      tick();
`endif
      in_valid = 1'b0; ex_mem_read = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_dst !== 5'd1) begin
         failures++; $display("FAIL hz_accept actual=%b/%0d required=1/1", out_valid, out_dst);
      end
      tick();
   endtask

   task automatic test_random();
      logic [31:0] pool [6];
      pool[0] = rtype(5'd2, 5'd3, 5'd1, 6'h20);
      pool[1] = itype(6'h23, 5'd4, 5'd2, 16'hFFF0);
      pool[2] = itype(6'h2b, 5'd2, 5'd3, 16'h0008);
      pool[3] = itype(6'h05, 5'd1, 5'd2, 16'h0002);
      pool[4] = itype(6'h08, 5'd2, 5'd6, 16'h7FFF);
      pool[5] = 32'h0C000000;
      for (int i = 0; i < 80; i++) begin
         in_valid    = 1'($urandom_range(0, 1));
         out_ready   = ($urandom_range(0, 3) != 0);
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_dst      = 5'($urandom_range(0, 4));
         in_instr    = pool[$urandom_range(0, 5)];
         in_pc       = 32'h00006000 + 32'(i * 4);
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1; ex_mem_read = 1'b0;
      for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) tick();
      checks++;
      if (sb_q.size() != 0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL drain_timeout pending=%0d out_valid=%b required=0/0", sb_q.size(), out_valid);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      ex_mem_read = 1'b0; ex_dst = '0; flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_add();
      test_lw();
      test_back_to_back();
      test_backpressure();
      test_flush_illegal();
      test_hazard();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
